// File: rtl/card_deck_dealer.sv
// -----------------------------------------------------------------------------
// card_deck_dealer
//
// Holds the 52-card deck for the blackjack game. On shuffle_start it refills
// the deck in order (deck[k] = k), runs SHUFFLE_PASSES Fisher-Yates passes
// driven by a free-running 16-bit Galois LFSR, then deals one card per
// deal_req until the deck is exhausted.
//
// Optional build macro:
//   DECK_AUTO_RESHUFFLE_EN - when defined, a deal_req while the deck is empty
//                            restarts the fill + shuffle, exactly as
//                            shuffle_start would. That request deals nothing.
//                            When undefined, EMPTY holds until shuffle_start
//                            or reset.
//
// Ports:
//   CLOCK_50      in   1  system clock
//   reset         in   1  synchronous, active-high
//   shuffle_start in   1  pulse: rebuild and shuffle the deck (any state)
//   deal_req      in   1  pulse: deal the next card (honoured only in READY)
//   card_valid    out  1  one-cycle pulse, card_* hold the dealt card
//   card_index    out  6  dealt card, 0..51
//   card_suit     out  2  card_index / 13
//   card_rank     out  4  (card_index mod 13) + 1, 1=A .. 13=K
//   card_points   out  4  blackjack value: A=1, 2..10 face value, J/Q/K=10
//   busy          out  1  high while filling or shuffling
//   deck_empty    out  1  high when every card has been dealt
//   cards_left    out  6  undealt cards, 0..52
//
// Handshake: deal_req is a single-cycle request sampled on the rising edge.
// If accepted, card_valid is high for exactly one cycle on the following
// cycle and card_* change only at that point; otherwise no pulse is produced.
// shuffle_start has priority over deal_req in the same cycle.
// -----------------------------------------------------------------------------
module card_deck_dealer #(
    parameter int unsigned SHUFFLE_PASSES = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       shuffle_start,
    input  logic       deal_req,
    output logic       card_valid,
    output logic [5:0] card_index,
    output logic [1:0] card_suit,
    output logic [3:0] card_rank,
    output logic [3:0] card_points,
    output logic       busy,
    output logic       deck_empty,
    output logic [5:0] cards_left
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        DRAW    = 3'd2,
        SWAP_RD = 3'd3,
        SWAP_WR = 3'd4,
        READY   = 3'd5,
        EMPTY   = 3'd6
    } state_t;

    localparam logic [7:0]  PASS_LIMIT = 8'(SHUFFLE_PASSES);
    localparam logic [5:0]  LAST_IDX   = 6'd51;
    localparam logic [5:0]  DECK_SIZE  = 6'd52;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    state_t      state;
    state_t      state_next;

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [5:0]  deck [0:51];

    logic [5:0]  fill_k;       // next deck slot to write during INIT
    logic [5:0]  i_idx;        // Fisher-Yates position being settled
    logic [5:0]  j_idx;        // accepted random partner for i_idx
    logic [7:0]  pass_cnt;     // completed shuffle passes
    logic [5:0]  ptr;          // next deck slot to deal
    logic [5:0]  swap_i_val;   // deck[i_idx] captured in SWAP_RD
    logic [5:0]  swap_j_val;   // deck[j_idx] captured in SWAP_RD

    // Control strobes from the next-state logic into the datapath.
    logic        restart;
    logic        fill_wr;
    logic        take_j;
    logic        swap_rd;
    logic        swap_wr;
    logic        enter_ready;
    logic        deal_fire;

    logic [5:0]  cand;
    logic        cand_ok;
    logic        pass_done;

    logic [5:0]  deal_card;
    logic [1:0]  dec_suit;
    logic [3:0]  dec_rem;
    logic [3:0]  dec_rank;
    logic [3:0]  dec_points;

    // Smallest all-ones mask covering top, so the candidate draw is uniform
    // over 0..mask and rejection sampling keeps it uniform over 0..top.
    function automatic logic [5:0] draw_mask(input logic [5:0] top);
        if (top >= 6'd32) begin
            return 6'd63;
        end else if (top >= 6'd16) begin
            return 6'd31;
        end else if (top >= 6'd8) begin
            return 6'd15;
        end else if (top >= 6'd4) begin
            return 6'd7;
        end else if (top >= 6'd2) begin
            return 6'd3;
        end else begin
            return 6'd1;
        end
    endfunction

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    assign cand      = lfsr[5:0] & draw_mask(i_idx);
    assign cand_ok   = (cand <= i_idx);
    // The swap at i_idx == 1 is the last of a pass.
    assign pass_done = (i_idx == 6'd1) && ((pass_cnt + 8'd1) == PASS_LIMIT);

    assign busy       = (state == INIT) || (state == DRAW) ||
                        (state == SWAP_RD) || (state == SWAP_WR);
    assign deck_empty = (state == EMPTY);

    // Card under the deal pointer; ptr only runs past 51 once the deck is
    // empty, where nothing is dealt.
    assign deal_card = (ptr < DECK_SIZE) ? deck[ptr] : 6'd0;

    // Suit/rank decode by compare-subtract against multiples of 13.
    always_comb begin
        dec_suit = 2'd0;
        dec_rem  = 4'(deal_card);
        if (deal_card >= 6'd39) begin
            dec_suit = 2'd3;
            dec_rem  = 4'(deal_card - 6'd39);
        end else if (deal_card >= 6'd26) begin
            dec_suit = 2'd2;
            dec_rem  = 4'(deal_card - 6'd26);
        end else if (deal_card >= 6'd13) begin
            dec_suit = 2'd1;
            dec_rem  = 4'(deal_card - 6'd13);
        end
        dec_rank   = dec_rem + 4'd1;
        dec_points = (dec_rank > 4'd10) ? 4'd10 : dec_rank;
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_next  = state;
        restart     = 1'b0;
        fill_wr     = 1'b0;
        take_j      = 1'b0;
        swap_rd     = 1'b0;
        swap_wr     = 1'b0;
        enter_ready = 1'b0;
        deal_fire   = 1'b0;

        if (shuffle_start) begin
            // Abort whatever is in progress, including a same-cycle deal.
            restart    = 1'b1;
            state_next = INIT;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                INIT: begin
                    fill_wr = 1'b1;
                    if (fill_k == LAST_IDX) begin
                        if (PASS_LIMIT == 8'd0) begin
                            state_next  = READY;
                            enter_ready = 1'b1;
                        end else begin
                            state_next = DRAW;
                        end
                    end
                end
                DRAW: begin
                    // A rejected candidate simply waits for the next LFSR step.
                    if (cand_ok) begin
                        take_j     = 1'b1;
                        state_next = SWAP_RD;
                    end
                end
                SWAP_RD: begin
                    swap_rd    = 1'b1;
                    state_next = SWAP_WR;
                end
                SWAP_WR: begin
                    swap_wr = 1'b1;
                    if (pass_done) begin
                        state_next  = READY;
                        enter_ready = 1'b1;
                    end else begin
                        state_next = DRAW;
                    end
                end
                READY: begin
                    if (deal_req) begin
                        deal_fire = 1'b1;
                        if (cards_left == 6'd1) begin
                            state_next = EMPTY;
                        end
                    end
                end
                EMPTY: begin
`ifdef DECK_AUTO_RESHUFFLE_EN
                    if (deal_req) begin
                        restart    = 1'b1;
                        state_next = INIT;
                    end
`else
                    state_next = EMPTY;
`endif
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Datapath registers and card outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            lfsr        <= LFSR_SEED;
            fill_k      <= 6'd0;
            i_idx       <= 6'd0;
            j_idx       <= 6'd0;
            pass_cnt    <= 8'd0;
            ptr         <= 6'd0;
            swap_i_val  <= 6'd0;
            swap_j_val  <= 6'd0;
            card_valid  <= 1'b0;
            card_index  <= 6'd0;
            card_suit   <= 2'd0;
            card_rank   <= 4'd0;
            card_points <= 4'd0;
            cards_left  <= 6'd0;
        end else begin
            // Free-running in every state so request timing adds entropy.
            lfsr       <= lfsr_next;
            card_valid <= deal_fire;

            if (restart) begin
                fill_k     <= 6'd0;
                ptr        <= 6'd0;
                cards_left <= 6'd0;
            end

            if (fill_wr) begin
                fill_k <= fill_k + 6'd1;
                if (fill_k == LAST_IDX) begin
                    i_idx    <= LAST_IDX;
                    pass_cnt <= 8'd0;
                end
            end

            if (take_j) begin
                j_idx <= cand;
            end

            if (swap_rd) begin
                swap_i_val <= deck[i_idx];
                swap_j_val <= deck[j_idx];
            end

            if (swap_wr) begin
                if (i_idx == 6'd1) begin
                    i_idx    <= LAST_IDX;
                    pass_cnt <= pass_cnt + 8'd1;
                end else begin
                    i_idx <= i_idx - 6'd1;
                end
            end

            if (enter_ready) begin
                ptr        <= 6'd0;
                cards_left <= DECK_SIZE;
            end

            if (deal_fire) begin
                card_index  <= deal_card;
                card_suit   <= dec_suit;
                card_rank   <= dec_rank;
                card_points <= dec_points;
                ptr         <= ptr + 6'd1;
                cards_left  <= cards_left - 6'd1;
            end
        end
    end

    // Deck storage. Contents are rebuilt by INIT, so no reset is needed.
    // With j_idx == i_idx both writes hit the same slot with its own value.
    always_ff @(posedge CLOCK_50) begin
        if (fill_wr) begin
            deck[fill_k] <= fill_k;
        end else if (swap_wr) begin
            deck[i_idx] <= swap_j_val;
            deck[j_idx] <= swap_i_val;
        end
    end

endmodule
